// File: rtl/bridge_wide_narrow.sv
// Host-to-narrow-bus width bridge: splits one HOST_WIDTH access into up to
// HOST_WIDTH/BUS_WIDTH bus beats, skipping beats whose byte enables are all zero.
module bridge_wide_narrow #(
    parameter int HOST_WIDTH = 32,
    parameter int BUS_WIDTH  = 16,
    parameter int ADDR_WIDTH = 30
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic                                                 h_cs,
    input  logic [ADDR_WIDTH-1:0]                                h_addr,
    input  logic [HOST_WIDTH-1:0]                                h_wdata,
    output logic [HOST_WIDTH-1:0]                                h_rdata,
    input  logic                                                 h_wr_en,
    input  logic [HOST_WIDTH/8-1:0]                              h_bytesel,
    output logic                                                 h_compl,
    output logic [ADDR_WIDTH+$clog2(HOST_WIDTH/BUS_WIDTH)-1:0]   b_addr,
    output logic [BUS_WIDTH-1:0]                                 b_wdata,
    input  logic [BUS_WIDTH-1:0]                                 b_rdata,
    output logic                                                 b_wr_en,
    output logic [BUS_WIDTH/8-1:0]                               b_bytesel,
    input  logic                                                 b_compl
);

    localparam int RATIO = HOST_WIDTH / BUS_WIDTH;
    localparam int IDXW  = $clog2(RATIO);
    localparam int HB    = HOST_WIDTH / 8;
    localparam int BB    = BUS_WIDTH / 8;

    if ((HOST_WIDTH % 8) != 0 || (BUS_WIDTH % 8) != 0 || (HOST_WIDTH % BUS_WIDTH) != 0 ||
        RATIO < 2 || (RATIO & (RATIO - 1)) != 0) begin : g_bad_params
        $error("bridge_wide_narrow: HOST_WIDTH/BUS_WIDTH must be a power of two >= 2");
    end

    typedef enum logic [1:0] {IDLE, XFER, COMPL} state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [HOST_WIDTH-1:0]   wdata_q;
    logic                    wr_q;
    logic [HB-1:0]           sel_q;
    logic [IDXW-1:0]         idx;

    logic                    first_ok;
    logic [IDXW-1:0]         first_idx;
    logic                    next_ok;
    logic [IDXW-1:0]         next_idx;

    // Lowest active beat of the incoming request, and next active beat above idx.
    always_comb begin
        first_ok  = 1'b0;
        first_idx = '0;
        next_ok   = 1'b0;
        next_idx  = '0;
        for (int unsigned i = 0; i < RATIO; i++) begin
            if (!first_ok && h_bytesel[i*BB +: BB] != '0) begin
                first_ok  = 1'b1;
                first_idx = IDXW'(i);
            end
            if (!next_ok && i > 32'(idx) && sel_q[i*BB +: BB] != '0) begin
                next_ok  = 1'b1;
                next_idx = IDXW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wr_q      <= 1'b0;
            sel_q     <= '0;
            idx       <= '0;
            h_rdata   <= '0;
            h_compl   <= 1'b0;
            b_addr    <= '0;
            b_wdata   <= '0;
            b_wr_en   <= 1'b0;
            b_bytesel <= '0;
        end else begin
            case (state)
                IDLE: begin
                    h_compl <= 1'b0;
                    if (h_cs && |h_bytesel) begin
                        addr_q    <= h_addr;
                        wdata_q   <= h_wdata;
                        wr_q      <= h_wr_en;
                        sel_q     <= h_bytesel;
                        idx       <= first_idx;
                        h_rdata   <= '0;
                        b_addr    <= {h_addr, first_idx};
                        b_wdata   <= h_wdata[32'(first_idx)*BUS_WIDTH +: BUS_WIDTH];
                        b_bytesel <= h_bytesel[32'(first_idx)*BB +: BB];
                        b_wr_en   <= h_wr_en;
                        state     <= XFER;
                    end
                end
                XFER: begin
                    if (b_compl) begin
                        if (!wr_q)
                            h_rdata[32'(idx)*BUS_WIDTH +: BUS_WIDTH] <= b_rdata;
                        if (next_ok) begin
                            idx       <= next_idx;
                            b_addr    <= {addr_q, next_idx};
                            b_wdata   <= wdata_q[32'(next_idx)*BUS_WIDTH +: BUS_WIDTH];
                            b_bytesel <= sel_q[32'(next_idx)*BB +: BB];
                        end else begin
                            b_addr    <= '0;
                            b_wdata   <= '0;
                            b_bytesel <= '0;
                            b_wr_en   <= 1'b0;
                            h_compl   <= 1'b1;
                            state     <= COMPL;
                        end
                    end
                end
                COMPL: begin
                    h_compl <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bridge_wide_narrow.sv
// Self-checking bench for bridge_wide_narrow: 32/16 instance driven by vectors,
// hand sequences and random transactions; 64/16 instance for the sparse write case.
module tb_bridge_wide_narrow;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    // 32/16 instance
    logic        cs, wr, bcompl, compl, bwr;
    logic [29:0] addr;
    logic [31:0] wdata, rdata;
    logic [3:0]  sel;
    logic [30:0] baddr;
    logic [15:0] bwdata, brdata;
    logic [1:0]  bsel;

    // 64/16 instance
    logic        cs6, wr6, bcompl6, compl6, bwr6;
    logic [29:0] addr6;
    logic [63:0] wdata6, rdata6;
    logic [7:0]  sel6;
    logic [31:0] baddr6;
    logic [15:0] bwdata6, brdata6;
    logic [1:0]  bsel6;

    bridge_wide_narrow #(.HOST_WIDTH(32), .BUS_WIDTH(16), .ADDR_WIDTH(30)) dut (
        .clk(clk), .rst(rst), .h_cs(cs), .h_addr(addr), .h_wdata(wdata), .h_rdata(rdata),
        .h_wr_en(wr), .h_bytesel(sel), .h_compl(compl), .b_addr(baddr), .b_wdata(bwdata),
        .b_rdata(brdata), .b_wr_en(bwr), .b_bytesel(bsel), .b_compl(bcompl)
    );

    bridge_wide_narrow #(.HOST_WIDTH(64), .BUS_WIDTH(16), .ADDR_WIDTH(30)) dut64 (
        .clk(clk), .rst(rst), .h_cs(cs6), .h_addr(addr6), .h_wdata(wdata6), .h_rdata(rdata6),
        .h_wr_en(wr6), .h_bytesel(sel6), .h_compl(compl6), .b_addr(baddr6), .b_wdata(bwdata6),
        .b_rdata(brdata6), .b_wr_en(bwr6), .b_bytesel(bsel6), .b_compl(bcompl6)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Host request plus a slave model. Expected beats come from the byte-enable
    // rule: beat i is issued iff its 2-bit enable slice is nonzero, in ascending order.
    task automatic run_xfer(input logic [29:0] a, input logic [31:0] wd, input logic w,
                            input logic [3:0] s, input logic [31:0] rd,
                            input int unsigned waits, input bit fixed_wait,
                            input bit scramble, output logic [31:0] got);
        logic [31:0] exp_rd;
        bit          first;
        int unsigned wt;
        exp_rd = '0;
        first  = 1'b1;
        cs = 1'b1; addr = a; wdata = wd; wr = w; sel = s; bcompl = 1'b0;
        tick();
        if (scramble) begin
            cs = 1'($urandom); addr = 30'($urandom); wdata = $urandom;
            sel = 4'($urandom); wr = 1'($urandom);
        end else begin
            cs = 1'b0;
        end
        for (int unsigned i = 0; i < 2; i++) begin
            if (s[2*i +: 2] != 2'b00) begin
                wt = fixed_wait ? waits : $urandom_range(waits, 0);
                for (int unsigned k = 0; k <= wt; k++) begin
                    chk("b_addr", 64'(baddr), 64'({a, i[0]}));
                    chk("b_bytesel", 64'(bsel), 64'(s[2*i +: 2]));
                    chk("b_wdata", 64'(bwdata), 64'(wd[16*i +: 16]));
                    chk("b_wr_en", 64'(bwr), 64'(w));
                    chk("h_compl_busy", 64'(compl), 64'(0));
                    if (first) chk("h_rdata_cleared", 64'(rdata), 64'(0));
                    first  = 1'b0;
                    bcompl = (k == wt);
                    brdata = (k == wt) ? rd[16*i +: 16] : 16'($urandom);
                    if (!w && k == wt) exp_rd[16*i +: 16] = rd[16*i +: 16];
                    tick();
                    bcompl = 1'b0;
                end
            end
        end
        chk("h_compl", 64'(compl), 64'(1));
        chk("b_bytesel_compl", 64'(bsel), 64'(0));
        chk("b_wr_en_compl", 64'(bwr), 64'(0));
        chk("h_rdata", 64'(rdata), 64'(exp_rd));
        got = rdata;
        // a request during COMPL must be ignored
        if (scramble) begin cs = 1'b1; sel = 4'hF; end
        tick();
        cs = 1'b0;
        chk("h_compl_after", 64'(compl), 64'(0));
        chk("b_bytesel_after", 64'(bsel), 64'(0));
        chk("h_rdata_hold", 64'(rdata), 64'(exp_rd));
    endtask

    typedef struct {
        logic [3:0]  sel;
        logic        wr;
        logic [29:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        int unsigned waits;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t        vecs[8];
    logic [31:0] got;

    initial begin
        vecs[0] = '{4'hF,    1'b0, 30'h10,  32'h0,        32'hDEADBEEF, 0, 32'hDEADBEEF};
        vecs[1] = '{4'b1100, 1'b0, 30'h22,  32'h0,        32'hDEADBEEF, 3, 32'hDEAD0000};
        vecs[2] = '{4'b0011, 1'b0, 30'h33,  32'h0,        32'hDEADBEEF, 1, 32'h0000BEEF};
        vecs[3] = '{4'b0100, 1'b0, 30'h44,  32'h0,        32'hDEADBEEF, 0, 32'hDEAD0000};
        vecs[4] = '{4'b0001, 1'b0, 30'h55,  32'h0,        32'h12345678, 2, 32'h00005678};
        vecs[5] = '{4'hF,    1'b1, 30'h66,  32'hA5A55A5A, 32'hFFFFFFFF, 0, 32'h00000000};
        vecs[6] = '{4'b1000, 1'b0, 30'h3FFFFFFF, 32'h0,   32'hCAFEF00D, 1, 32'hCAFE0000};
        vecs[7] = '{4'b0110, 1'b0, 30'h0,   32'h0,        32'h87654321, 0, 32'h87654321};

        rst = 1'b1;
        cs = 0; wr = 0; bcompl = 0; addr = '0; wdata = '0; sel = '0; brdata = '0;
        cs6 = 0; wr6 = 0; bcompl6 = 0; addr6 = '0; wdata6 = '0; sel6 = '0; brdata6 = '0;
        tick();
        tick();
        chk("rst_h_rdata", 64'(rdata), 64'(0));
        chk("rst_h_compl", 64'(compl), 64'(0));
        chk("rst_b_addr", 64'(baddr), 64'(0));
        chk("rst_b_wdata", 64'(bwdata), 64'(0));
        chk("rst_b_wr_en", 64'(bwr), 64'(0));
        chk("rst_b_bytesel", 64'(bsel), 64'(0));
        chk("rst64_b_bytesel", 64'(bsel6), 64'(0));
        rst = 1'b0;
        tick();

        // table-driven vectors
        for (int i = 0; i < 8; i++) begin
            run_xfer(vecs[i].addr, vecs[i].wdata, vecs[i].wr, vecs[i].sel, vecs[i].rd,
                     vecs[i].waits, 1'b1, 1'b0, got);
            chk($sformatf("vec%0d_rdata", i), 64'(got), 64'(vecs[i].exp_rdata));
        end

        // input instability after acceptance
        run_xfer(30'h1234, 32'h89ABCDEF, 1'b1, 4'hF, 32'h0, 0, 1'b1, 1'b1, got);
        run_xfer(30'h0BAD, 32'h0, 1'b0, 4'b1001, 32'h5555AAAA, 2, 1'b1, 1'b1, got);

        // h_cs held high with a zero-wait slave: one transfer every 4 cycles
        cs = 1'b1; addr = 30'h77; wdata = 32'h11112222; wr = 1'b1; sel = 4'hF;
        bcompl = 1'b1; brdata = 16'h0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("b2b_h_compl", 64'(compl), 64'((k % 4) == 3));
            chk("b2b_b_bytesel", 64'(bsel), ((k % 4) == 1 || (k % 4) == 2) ? 64'd3 : 64'd0);
        end
        cs = 1'b0; bcompl = 1'b0;
        tick();
        tick();

        // reset during beat 1 of 2
        cs = 1'b1; addr = 30'h7; sel = 4'hF; wr = 1'b0;
        tick();
        cs = 1'b0;
        chk("rstx_beat0", 64'(bsel), 64'(3));
        bcompl = 1'b1; brdata = 16'h1234;
        tick();
        bcompl = 1'b0;
        chk("rstx_beat1_addr", 64'(baddr), 64'({30'h7, 1'b1}));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstx_h_rdata", 64'(rdata), 64'(0));
        chk("rstx_h_compl", 64'(compl), 64'(0));
        chk("rstx_b_addr", 64'(baddr), 64'(0));
        chk("rstx_b_wdata", 64'(bwdata), 64'(0));
        chk("rstx_b_bytesel", 64'(bsel), 64'(0));
        chk("rstx_b_wr_en", 64'(bwr), 64'(0));
        bcompl = 1'b1;
        tick();
        bcompl = 1'b0;
        chk("rstx_idle_compl", 64'(compl), 64'(0));
        chk("rstx_idle_bsel", 64'(bsel), 64'(0));
        run_xfer(30'h99, 32'h0, 1'b0, 4'hF, 32'hFEEDC0DE, 1, 1'b1, 1'b0, got);
        chk("rstx_fresh_rdata", 64'(got), 64'(32'hFEEDC0DE));

        // zero enables and stray b_compl in IDLE
        cs = 1'b1; sel = 4'h0; addr = 30'h5;
        for (int k = 0; k < 4; k++) begin
            bcompl = 1'(k & 1);
            tick();
            chk("zero_b_bytesel", 64'(bsel), 64'(0));
            chk("zero_h_compl", 64'(compl), 64'(0));
            chk("zero_h_rdata_hold", 64'(rdata), 64'(32'hFEEDC0DE));
        end
        cs = 1'b0; bcompl = 1'b0;
        tick();

        // sparse 64/16 write: beats 0 and 3 only
        cs6 = 1'b1; addr6 = 30'h5; wr6 = 1'b1; sel6 = 8'b1100_0001;
        wdata6 = 64'h4444_3333_2222_1111;
        tick();
        cs6 = 1'b0; sel6 = 8'hFF; wdata6 = '1;
        chk("w64_b0_addr", 64'(baddr6), 64'({30'h5, 2'd0}));
        chk("w64_b0_wdata", 64'(bwdata6), 64'h1111);
        chk("w64_b0_bsel", 64'(bsel6), 64'(2'b01));
        chk("w64_b0_wr", 64'(bwr6), 64'(1));
        bcompl6 = 1'b1;
        tick();
        chk("w64_b3_addr", 64'(baddr6), 64'({30'h5, 2'd3}));
        chk("w64_b3_wdata", 64'(bwdata6), 64'h4444);
        chk("w64_b3_bsel", 64'(bsel6), 64'(2'b11));
        chk("w64_b3_wr", 64'(bwr6), 64'(1));
        chk("w64_busy_compl", 64'(compl6), 64'(0));
        tick();
        bcompl6 = 1'b0;
        chk("w64_h_compl", 64'(compl6), 64'(1));
        chk("w64_h_rdata", rdata6, 64'h0);
        chk("w64_bsel_done", 64'(bsel6), 64'(0));
        tick();
        chk("w64_h_compl_once", 64'(compl6), 64'(0));

        // randomized transactions
        for (int n = 0; n < 40; n++) begin
            run_xfer(30'($urandom), $urandom, 1'($urandom), 4'($urandom_range(15, 1)),
                     $urandom, 3, 1'b0, 1'($urandom), got);
            for (int g = 0; g < int'($urandom_range(2, 0)); g++) begin
                tick();
                chk("gap_h_compl", 64'(compl), 64'(0));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
